// File: rtl/core_pkg.sv
// Fetch-path types shared by the core front end: the queued fetch entry and
// the bubble encoding used whenever no real instruction is present.
package core_pkg;

  localparam logic [31:0] INSTR_BUBBLE = 32'd0;
  localparam logic [31:0] PC_NONE      = 32'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t FETCH_EMPTY = '{pc: PC_NONE, instr: INSTR_BUBBLE};

endpackage

// File: rtl/core_fetch_queue_if.sv
// Fetch queue bus: the adapter/redirect side drives i_*, the queue drives the
// head entry and status back on o_*.
interface core_fetch_queue_if #(
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   i_pc;
  logic [31:0]   i_instr;
  logic          i_valid;
  logic          i_flush;
  logic          i_deq;
  logic [31:0]   o_pc;
  logic [31:0]   o_instr;
  logic          o_valid;
  logic          o_full;
  logic [CW-1:0] o_count;
  logic          o_overflow;

  modport master (
    output i_pc, i_instr, i_valid, i_flush, i_deq,
    input  o_pc, o_instr, o_valid, o_full, o_count, o_overflow
  );

  modport slave (
    input  i_pc, i_instr, i_valid, i_flush, i_deq,
    output o_pc, o_instr, o_valid, o_full, o_count, o_overflow
  );

endinterface

// File: rtl/core_fetch_queue.sv
// First-word-fall-through instruction fetch queue between the instruction bus
// adapter and decode; flush discards everything, overflow is a sticky error.
module core_fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  core_fetch_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic          full_s;
  logic          nonempty_s;
  logic          enq_s;
  logic          deq_s;
  logic          drop_s;
  fetch_entry_t  wr_entry_s;
  fetch_entry_t  head_s;

  // Handshake decode; status comes only from registered occupancy.
  always_comb begin
    full_s       = (count_r == COUNT_FULL);
    nonempty_s   = (count_r != {CW{1'b0}});
    deq_s        = bus.i_deq & nonempty_s & ~bus.i_flush;
    enq_s        = bus.i_valid & ~bus.i_flush & (~full_s | (bus.i_deq & nonempty_s));
    drop_s       = bus.i_valid & ~bus.i_flush & full_s & ~(bus.i_deq & nonempty_s);
    wr_entry_s.pc    = bus.i_pc;
    wr_entry_s.instr = bus.i_instr;
  end

  // Head entry falls through from storage, masked to a bubble when empty.
  always_comb begin
    if (nonempty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = FETCH_EMPTY;
    end
  end

  // Occupancy, pointers and sticky overflow; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= {CW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      overflow_r <= 1'b0;
    end else if (bus.i_flush) begin
      count_r    <= {CW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Entry storage is deliberately left unreset; emptiness masks stale data.
  always_ff @(posedge clk) begin
    if (!rst && enq_s) begin
      mem_r[wr_ptr_r] <= wr_entry_s;
    end
  end

  assign bus.o_pc       = head_s.pc;
  assign bus.o_instr    = head_s.instr;
  assign bus.o_valid    = nonempty_s;
  assign bus.o_full     = full_s;
  assign bus.o_count    = count_r;
  assign bus.o_overflow = overflow_r;

endmodule

// File: tb/tb_core_fetch_queue.sv
// Directed and random checks of core_fetch_queue against a queue-based model.
module tb_core_fetch_queue;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [63:0] mq[$];
  bit          movf;

  core_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  core_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: one cycle of the queue rules applied to a SV queue.
  task automatic model_step(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                            input bit f, input bit d, input bit r);
    bit dq;
    bit acc;
    if (r) begin
      mq.delete();
      movf = 1'b0;
    end else if (f) begin
      mq.delete();
    end else begin
      dq  = d && (mq.size() > 0);
      acc = v && ((mq.size() < DEPTH) || dq);
      if (v && !acc) movf = 1'b1;
      if (dq) void'(mq.pop_front());
      if (acc) mq.push_back({pc, instr});
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] head;
    head = (mq.size() > 0) ? mq[0] : 64'd0;
    chk({tag, "_valid"}, 64'(bus.o_valid),    64'(mq.size() > 0));
    chk({tag, "_count"}, 64'(bus.o_count),    64'(mq.size()));
    chk({tag, "_full"},  64'(bus.o_full),     64'(mq.size() == DEPTH));
    chk({tag, "_ovf"},   64'(bus.o_overflow), 64'(movf));
    chk({tag, "_pc"},    64'(bus.o_pc),       64'(head[63:32]));
    chk({tag, "_instr"}, 64'(bus.o_instr),    64'(head[31:0]));
  endtask

  // One clock: drive, confirm status ignores same-cycle inputs, clock, check.
  task automatic cyc(input string tag, input bit v, input logic [31:0] pc,
                     input logic [31:0] instr, input bit f, input bit d, input bit r);
    bus.i_valid = v;
    bus.i_pc    = pc;
    bus.i_instr = instr;
    bus.i_flush = f;
    bus.i_deq   = d;
    rst         = r;
    #1;
    if (!$isunknown(bus.o_count)) begin
      chk({tag, "_pre_count"}, 64'(bus.o_count), 64'(mq.size()));
      chk({tag, "_pre_full"},  64'(bus.o_full),  64'(mq.size() == DEPTH));
    end
    @(posedge clk);
    model_step(v, pc, instr, f, d, r);
    #1;
    check_all(tag);
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'h0013_0000 ^ (pc << 4);
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    movf  = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_pc    = 32'd0;
    bus.i_instr = 32'd0;
    bus.i_flush = 1'b0;
    bus.i_deq   = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    #1;

    cyc("reset", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cyc("deq_empty", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Fill to DEPTH without dequeue.
    for (int i = 0; i < 4; i++) begin
      cyc("fill", 1'b1, 32'h100 + 32'(4 * i), word_of(32'h100 + 32'(4 * i)), 1'b0, 1'b0, 1'b0);
    end
    chk("fill_full",  64'(bus.o_full),  64'd1);
    chk("fill_count", 64'(bus.o_count), 64'd4);
    chk("fill_pc",    64'(bus.o_pc),    64'h100);
    chk("fill_instr", 64'(bus.o_instr), 64'(word_of(32'h100)));

    // Full with simultaneous enqueue and dequeue.
    cyc("full_swap", 1'b1, 32'h110, word_of(32'h110), 1'b0, 1'b1, 1'b0);
    chk("swap_pc",    64'(bus.o_pc),       64'h104);
    chk("swap_count", 64'(bus.o_count),    64'd4);
    chk("swap_ovf",   64'(bus.o_overflow), 64'd0);

    // Full with no dequeue: dropped, sticky overflow survives flush.
    cyc("full_drop", 1'b1, 32'h114, word_of(32'h114), 1'b0, 1'b0, 1'b0);
    chk("drop_ovf",   64'(bus.o_overflow), 64'd1);
    chk("drop_count", 64'(bus.o_count),    64'd4);
    cyc("drop_flush", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("flush_ovf_held", 64'(bus.o_overflow), 64'd1);

    // Flush priority over same-cycle enqueue and dequeue.
    cyc("clr", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc("three", 1'b1, 32'h180 + 32'(4 * i), word_of(32'h180 + 32'(4 * i)), 1'b0, 1'b0, 1'b0);
    end
    cyc("flush_pri", 1'b1, 32'h1F0, word_of(32'h1F0), 1'b1, 1'b1, 1'b0);
    chk("flush_count", 64'(bus.o_count), 64'd0);
    chk("flush_valid", 64'(bus.o_valid), 64'd0);
    chk("flush_instr", 64'(bus.o_instr), 64'd0);
    cyc("after_flush", 1'b1, 32'h200, word_of(32'h200), 1'b0, 1'b0, 1'b0);
    chk("after_flush_pc", 64'(bus.o_pc), 64'h200);

    // Streaming with continuous dequeue wraps the pointers.
    cyc("pre_stream", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc("stream", 1'b1, 32'h100 + 32'(4 * i), word_of(32'h100 + 32'(4 * i)), 1'b0, 1'b1, 1'b0);
      chk("stream_pc", 64'(bus.o_pc), 64'(32'h100 + 32'(4 * i)));
      chk("stream_cnt_le1", 64'(bus.o_count <= 3'd1), 64'd1);
    end
    cyc("stream_drain", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Reset mid-operation overrides enqueue and dequeue.
    cyc("two_a", 1'b1, 32'h300, word_of(32'h300), 1'b0, 1'b0, 1'b0);
    cyc("two_b", 1'b1, 32'h304, word_of(32'h304), 1'b0, 1'b0, 1'b0);
    cyc("mid_rst", 1'b1, 32'h308, word_of(32'h308), 1'b0, 1'b1, 1'b1);
    chk("rst_valid", 64'(bus.o_valid),    64'd0);
    chk("rst_count", 64'(bus.o_count),    64'd0);
    chk("rst_ovf",   64'(bus.o_overflow), 64'd0);
    chk("rst_pc",    64'(bus.o_pc),       64'd0);

    // Random traffic; bubbles and rare flush/reset mixed in.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      logic [31:0] rins;
      rpc  = $urandom & 32'hFFFF_FFFC;
      rins = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      cyc("rand", 1'($urandom_range(0, 3) != 0), rpc, rins,
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
